cpu_test_sequencer: RTL and testbench
=====================================

# cpu_test_sequencer

Synthesisable, parametrised test harness for the pipelined CPU wrapper. It preloads a program image into CPU instruction memory through a backdoor write port while holding the CPU in reset, then releases reset. While the CPU runs it drives the CPU input port from a PC-triggered stimulus table and checks every CPU output-port write against an expected-value table. It sits between a host or bench and `CPU_WrapperV3`, so on-chip self-test runs without a simulator.

## Interface
Parameters:
- `DATA_W`, 8, data/instruction width; also the width of `i_port` and `o_port`
- `ADDR_W`, 8, CPU memory address and PC width
- `PROG_DEPTH`, 16, program image table entries
- `STIM_DEPTH`, 4, stimulus table entries
- `CHK_DEPTH`, 4, expected-output table entries
- `TIMEOUT_CYC`, 1024, run watchdog limit; used only with `CPUSEQ_TIMEOUT_EN`

Ports:
- `clk`  in  1  single clock
- `rstn`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  table write strobe
- `cfg_sel`  in  2  table select: 0 prog, 1 stim_pc, 2 stim_val, 3 chk
- `cfg_addr`  in  clog2(max depth)  table index
- `cfg_wdata`  in  DATA_W  table write data
- `prog_len`  in  clog2(PROG_DEPTH)+1  words to load, 0..PROG_DEPTH
- `stim_cnt`  in  clog2(STIM_DEPTH)+1  valid stimulus entries
- `chk_cnt`  in  clog2(CHK_DEPTH)+1  valid check entries
- `start`  in  1  single-cycle start pulse
- `cpu_pc`  in  ADDR_W  CPU current PC
- `cpu_out`  in  DATA_W  CPU O_Port
- `cpu_out_stb`  in  1  one-cycle strobe, high when an OUT instruction commits
- `cpu_rstn`  out  1  active-low reset to the CPU
- `mem_we`  out  1  backdoor memory write enable
- `mem_addr`  out  ADDR_W  backdoor address
- `mem_wdata`  out  DATA_W  backdoor data
- `i_port`  out  DATA_W  CPU I_Port drive
- `busy`  out  1  high in LOAD or RUN
- `done`, `pass`, `fail`, `timeout`  out  1 each  sticky result flags
- `fail_idx`  out  clog2(CHK_DEPTH)  check index that mismatched
- `fail_data`  out  DATA_W  observed value at the mismatch

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- Reset values: every output is 0, including `cpu_rstn`; all indices are 0. Table contents are not reset.
- `cfg_we` writes the selected table in IDLE or DONE. It is ignored in LOAD and RUN. An out-of-range `cfg_addr` is dropped.
- `prog_len`, `stim_cnt` and `chk_cnt` are sampled on `start`. A sampled value above its table depth saturates to the depth.
- IDLE or DONE, on `start`:
  - clear all result flags and indices;
  - go to LOAD if `prog_len` is non-zero, otherwise go to RUN.
- LOAD:
  - `mem_we` is 1 and `mem_addr`/`mem_wdata` equal word k of the program table, for k = 0..prog_len-1, one word per cycle;
  - `cpu_rstn` stays 0;
  - after the last word, go to RUN.
- RUN:
  - `cpu_rstn` is 1;
  - Stimulus: while stim index s < stim_cnt and `cpu_pc` == stim_pc[s], the next edge sets `i_port` to stim_val[s] and increments s. `i_port` holds its last value otherwise.
  - Check: on `cpu_out_stb` with check index c < chk_cnt, compare `cpu_out` with chk[c].
    - Mismatch: set `fail`, `fail_idx`=c, `fail_data`=`cpu_out`, go to DONE.
    - Match on c == chk_cnt-1: set `pass`, go to DONE.
    - Any other match: increment c.
  - A stimulus match and a check in the same cycle are both processed.
  - chk_cnt == 0: `pass` is set on the first RUN cycle.
- DONE:
  - `done` is 1 and `cpu_rstn` is 0;
  - `i_port` holds its value;
  - strobes are ignored.
- `start` is ignored while in LOAD or RUN.
- `rstn` asserted mid-operation forces IDLE immediately and asynchronously; `cpu_rstn` goes to 0.

## Timing
- `start` at edge N puts LOAD at N+1. The first `mem_we` is visible in cycle N+1.
- LOAD lasts exactly prog_len cycles. `cpu_rstn` rises the cycle after the last write.
- Stimulus latency is 1 cycle: PC match in cycle t gives the new `i_port` in cycle t+1.
- Check result latency is 1 cycle: strobe in cycle t gives `done`/`pass`/`fail` in cycle t+1.
- `busy` is high exactly during LOAD and RUN.

## Configuration
- `CPUSEQ_TIMEOUT_EN`
  - Defined: a RUN-cycle counter starts at 0 on entry to RUN. If it reaches TIMEOUT_CYC-1 with no pass or fail, the next edge sets `fail` and `timeout`, sets `fail_idx` to the current c, and goes to DONE.
  - Pass or fail in the same cycle as the timeout takes priority over the timeout.
  - Not defined: no counter, `timeout` is tied to 0, and RUN is unbounded.

## Test plan
- Load program {7C,7D,21,78,7E,B2,89,31,78,B2}, prog_len=10:
  - expect 10 consecutive `mem_we` cycles with addresses 0..9 and matching data;
  - then `cpu_rstn`=1.
- Stimulus pc {0,1,4} with values {5,3,7}:
  - `i_port` reads 5, 3, 7, each one cycle after the PC match;
  - the CPU outputs 8, then 5;
  - with chk={8,5}, chk_cnt=2: `pass`=1, `fail`=0, `done`=1.
- Same program with chk={8,6}:
  - `fail`=1, `fail_idx`=1, `fail_data`=5;
  - `cpu_rstn` returns to 0.
- chk_cnt=0, prog_len=0: `start` -> RUN -> `pass`=1 one cycle later, with no `mem_we` pulses.
- Assert `rstn` mid-LOAD at word 3: all outputs go to 0 and the state is IDLE; a new `start` reloads from address 0.
- `CPUSEQ_TIMEOUT_EN` with TIMEOUT_CYC=16 and `cpu_out_stb` never asserted: `timeout`=1 and `fail`=1 after 16 RUN cycles.

Source files
------------

// File: rtl/cpu_test_sequencer.sv
// Self-test sequencer for the pipelined CPU wrapper: backdoor program load, PC-triggered stimulus, output checking.
// Optional run watchdog is compiled in with `define CPUSEQ_TIMEOUT_EN.
module cpu_test_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int PROG_DEPTH  = 16,
  parameter int STIM_DEPTH  = 4,
  parameter int CHK_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              cfg_we,
  input  logic [1:0]                        cfg_sel,
  input  logic [$clog2((PROG_DEPTH > STIM_DEPTH ? (PROG_DEPTH > CHK_DEPTH ? PROG_DEPTH : CHK_DEPTH)
                                                : (STIM_DEPTH > CHK_DEPTH ? STIM_DEPTH : CHK_DEPTH)))-1:0] cfg_addr,
  input  logic [DATA_W-1:0]                 cfg_wdata,
  input  logic [$clog2(PROG_DEPTH):0]       prog_len,
  input  logic [$clog2(STIM_DEPTH):0]       stim_cnt,
  input  logic [$clog2(CHK_DEPTH):0]        chk_cnt,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 cpu_pc,
  input  logic [DATA_W-1:0]                 cpu_out,
  input  logic                              cpu_out_stb,
  output logic                              cpu_rstn,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic [DATA_W-1:0]                 i_port,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic                              timeout,
  output logic [$clog2(CHK_DEPTH)-1:0]      fail_idx,
  output logic [DATA_W-1:0]                 fail_data
);

  localparam int PW  = $clog2(PROG_DEPTH);
  localparam int SW  = $clog2(STIM_DEPTH);
  localparam int CW  = $clog2(CHK_DEPTH);
  localparam int PLW = PW + 1;
  localparam int SLW = SW + 1;
  localparam int CLW = CW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] prog_tbl     [PROG_DEPTH];
  logic [ADDR_W-1:0] stim_pc_tbl  [STIM_DEPTH];
  logic [DATA_W-1:0] stim_val_tbl [STIM_DEPTH];
  logic [DATA_W-1:0] chk_tbl      [CHK_DEPTH];

  logic [PLW-1:0] k, plen;
  logic [SLW-1:0] s, scnt;
  logic [CLW-1:0] c, ccnt;

  logic cfg_open;
  logic run_pass, run_fail, stim_hit;
  logic to_hit;

  assign cfg_open = (state == ST_IDLE) || (state == ST_DONE);

  // Tables are plain storage with no reset; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_open) begin
      case (cfg_sel)
        2'd0: if (32'(cfg_addr) < PROG_DEPTH) prog_tbl[cfg_addr[PW-1:0]] <= cfg_wdata;
        2'd1: if (32'(cfg_addr) < STIM_DEPTH) stim_pc_tbl[cfg_addr[SW-1:0]] <= ADDR_W'(cfg_wdata);
        2'd2: if (32'(cfg_addr) < STIM_DEPTH) stim_val_tbl[cfg_addr[SW-1:0]] <= cfg_wdata;
        default: if (32'(cfg_addr) < CHK_DEPTH) chk_tbl[cfg_addr[CW-1:0]] <= cfg_wdata;
      endcase
    end
  end

`ifdef CPUSEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] run_cyc;
  logic          timeout_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cyc <= '0;
    end else if (state != ST_RUN) begin
      run_cyc <= '0;
    end else begin
      run_cyc <= run_cyc + 1'b1;
    end
  end

  assign to_hit  = (state == ST_RUN) && !run_pass && !run_fail &&
                   (run_cyc == TW'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rstn  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    run_pass  = 1'b0;
    run_fail  = 1'b0;
    stim_hit  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) state_nx = (prog_len != '0) ? ST_LOAD : ST_RUN;
      end
      ST_LOAD: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(k);
        mem_wdata = prog_tbl[k[PW-1:0]];
        if (k == plen - 1'b1) state_nx = ST_RUN;
      end
      default: begin
        busy     = 1'b1;
        cpu_rstn = 1'b1;
        stim_hit = (s < scnt) && (cpu_pc == stim_pc_tbl[s[SW-1:0]]);
        if (ccnt == '0) begin
          run_pass = 1'b1;
        end else if (cpu_out_stb && (c < ccnt)) begin
          if (cpu_out != chk_tbl[c[CW-1:0]]) run_fail = 1'b1;
          else if (c == ccnt - 1'b1)        run_pass = 1'b1;
        end
        if (run_pass || run_fail || to_hit) state_nx = ST_DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      k         <= '0;
      plen      <= '0;
      s         <= '0;
      scnt      <= '0;
      c         <= '0;
      ccnt      <= '0;
      i_port    <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_idx  <= '0;
      fail_data <= '0;
`ifdef CPUSEQ_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            k         <= '0;
            s         <= '0;
            c         <= '0;
            plen      <= (32'(prog_len) > PROG_DEPTH) ? PLW'(PROG_DEPTH) : prog_len;
            scnt      <= (32'(stim_cnt) > STIM_DEPTH) ? SLW'(STIM_DEPTH) : stim_cnt;
            ccnt      <= (32'(chk_cnt)  > CHK_DEPTH)  ? CLW'(CHK_DEPTH)  : chk_cnt;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_idx  <= '0;
            fail_data <= '0;
`ifdef CPUSEQ_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        ST_LOAD: k <= k + 1'b1;
        default: begin
          if (stim_hit) begin
            i_port <= stim_val_tbl[s[SW-1:0]];
            s      <= s + 1'b1;
          end
          // Verdict priority: mismatch, then pass, then watchdog, else advance on a matching strobe.
          if (run_fail) begin
            fail      <= 1'b1;
            fail_idx  <= c[CW-1:0];
            fail_data <= cpu_out;
          end else if (run_pass) begin
            pass <= 1'b1;
          end else if (to_hit) begin
            fail      <= 1'b1;
            fail_idx  <= c[CW-1:0];
`ifdef CPUSEQ_TIMEOUT_EN
            timeout_q <= 1'b1;
`endif
          end else if (cpu_out_stb && (c < ccnt)) begin
            c <= c + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer: the bench plays the CPU by driving cpu_pc / cpu_out / cpu_out_stb.
module tb_cpu_test_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = '0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [4:0] prog_len = '0;
  logic [2:0] stim_cnt = '0;
  logic [2:0] chk_cnt = '0;
  logic       start = 1'b0;
  logic [7:0] cpu_pc = 8'hFF;
  logic [7:0] cpu_out = '0;
  logic       cpu_out_stb = 1'b0;

  logic       cpu_rstn, mem_we, busy, done, pass, fail, timeout;
  logic [7:0] mem_addr, mem_wdata, i_port, fail_data;
  logic [1:0] fail_idx;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_test_sequencer #(
    .DATA_W(8), .ADDR_W(8), .PROG_DEPTH(16), .STIM_DEPTH(4), .CHK_DEPTH(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .prog_len(prog_len), .stim_cnt(stim_cnt), .chk_cnt(chk_cnt),
    .start(start), .cpu_pc(cpu_pc), .cpu_out(cpu_out), .cpu_out_stb(cpu_out_stb),
    .cpu_rstn(cpu_rstn), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_port(i_port), .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_idx(fail_idx), .fail_data(fail_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] sel, input logic [3:0] addr, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
    step();
    cfg_we = 1'b0;
  endtask

  // Plays the CPU: pc 0..4 with stimulus landing one cycle later, then OUT commits of o1 and o2.
  task automatic play_cpu(input logic [7:0] o1, input logic [7:0] o2);
    cpu_pc = 8'd0; step(); check("stim0_iport", i_port, 8'h05);
    cpu_pc = 8'd1; step(); check("stim1_iport", i_port, 8'h03);
    cpu_pc = 8'd2; step(); check("stim_hold", i_port, 8'h03);
    cpu_pc = 8'd3; step();
    cpu_pc = 8'd4; step(); check("stim2_iport", i_port, 8'h07);
    cpu_pc = 8'd5; cpu_out = o1; cpu_out_stb = 1'b1; step(); cpu_out_stb = 1'b0;
    check("first_out_not_done", {29'd0, done, pass, fail}, 32'd0);
    cpu_pc = 8'd6; step();
    cpu_pc = 8'd7; cpu_out = o2; cpu_out_stb = 1'b1; step(); cpu_out_stb = 1'b0;
    cpu_pc = 8'hFF;
  endtask

  logic [7:0] prog [10];
  int nwe;

  initial begin
    prog = '{8'h7C, 8'h7D, 8'h21, 8'h78, 8'h7E, 8'hB2, 8'h89, 8'h31, 8'h78, 8'hB2};

    #1 rstn = 1'b0;
    #1;
    check("rst_flags", {25'd0, cpu_rstn, mem_we, busy, done, pass, fail, timeout}, 32'd0);
    check("rst_iport", i_port, 8'h00);
    check("rst_faildata", {22'd0, fail_idx, fail_data}, 32'd0);
    step(); step();
    rstn = 1'b1;
    step();

    for (int i = 0; i < 10; i++) cfg(2'd0, 4'(i), prog[i]);
    cfg(2'd1, 4'd0, 8'd0); cfg(2'd1, 4'd1, 8'd1); cfg(2'd1, 4'd2, 8'd4);
    cfg(2'd2, 4'd0, 8'd5); cfg(2'd2, 4'd1, 8'd3); cfg(2'd2, 4'd2, 8'd7);
    cfg(2'd3, 4'd0, 8'd8); cfg(2'd3, 4'd1, 8'd5);
    // Out-of-range writes must not alias onto index 0 / 1.
    cfg(2'd1, 4'd4, 8'h33);
    cfg(2'd3, 4'd5, 8'h99);

    // Run 1: full load, stimulus, passing checks.
    prog_len = 5'd10; stim_cnt = 3'd3; chk_cnt = 3'd2; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("load_we_busy_rst", {29'd0, mem_we, busy, cpu_rstn}, 32'b110);
      check("load_addr", mem_addr, 32'(i));
      check("load_data", mem_wdata, prog[i]);
      step();
    end
    check("run_entry", {29'd0, cpu_rstn, mem_we, busy}, 32'b101);
    play_cpu(8'd8, 8'd5);
    check("pass_flags", {27'd0, done, pass, fail, busy, cpu_rstn}, 32'b11000);

    // Run 2: chk[1]=6 gives a mismatch; start/cfg during LOAD/RUN are ignored.
    cfg(2'd3, 4'd1, 8'd6);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("reload_addr", mem_addr, 32'(i));
      if (i == 3) start = 1'b1;
      step();
      start = 1'b0;
    end
    cfg(2'd3, 4'd0, 8'hFF);
    check("cfg_in_run_still_running", {30'd0, busy, cpu_rstn}, 32'b11);
    play_cpu(8'd8, 8'd5);
    check("fail_flags", {27'd0, done, pass, fail, busy, cpu_rstn}, 32'b10100);
    check("fail_idx", fail_idx, 2'd1);
    check("fail_data", fail_data, 8'd5);
    cpu_out = 8'h00; cpu_out_stb = 1'b1; step(); cpu_out_stb = 1'b0;
    check("done_ignores_stb", {fail_data, i_port}, {8'd5, 8'd7});
    check("done_holds", {30'd0, done, fail}, 32'b11);

    // Run 3: no program, no checks -> pass one cycle after entering RUN.
    prog_len = 5'd0; stim_cnt = 3'd0; chk_cnt = 3'd0; start = 1'b1;
    step(); start = 1'b0;
    check("empty_run_entry", {27'd0, busy, cpu_rstn, mem_we, fail, done}, 32'b11000);
    step();
    check("empty_pass", {29'd0, done, pass, fail}, 32'b110);
    check("empty_cleared", {22'd0, fail_idx, fail_data}, 32'd0);

    // Run 4: prog_len above depth saturates to 16 words.
    prog_len = 5'd31; start = 1'b1;
    step(); start = 1'b0;
    nwe = 0;
    for (int i = 0; i < 40 && mem_we; i++) begin
      nwe++;
      step();
    end
    check("sat_load_len", nwe, 32'd16);
    check("sat_run", cpu_rstn, 1'b1);
    step();
    check("sat_pass", pass, 1'b1);

    // Run 5: asynchronous reset mid-LOAD, then reload from address 0.
    prog_len = 5'd10; chk_cnt = 3'd2; stim_cnt = 3'd3; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    check("midload_addr", mem_addr, 8'd3);
    rstn = 1'b0;
    #1;
    check("async_rst_flags", {25'd0, cpu_rstn, mem_we, busy, done, pass, fail, timeout}, 32'd0);
    check("async_rst_data", {i_port, mem_addr}, 16'd0);
    step();
    rstn = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    check("reload0", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'd0, 8'h7C});
    step();
    check("reload1", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'd1, 8'h7D});

    // Run 6: no strobes with one pending check.
    rstn = 1'b0; step(); rstn = 1'b1; step();
    prog_len = 5'd0; stim_cnt = 3'd0; chk_cnt = 3'd1; start = 1'b1;
    step(); start = 1'b0;
    for (int i = 0; i < 15; i++) step();
`ifdef CPUSEQ_TIMEOUT_EN
    check("pre_timeout", {29'd0, fail, timeout, done}, 32'd0);
    step();
    check("timeout_flags", {28'd0, done, pass, fail, timeout}, 32'b1011);
    check("timeout_idx", fail_idx, 2'd0);
    check("timeout_rst", cpu_rstn, 1'b0);
`else
    for (int i = 0; i < 10; i++) step();
    check("no_timeout", {28'd0, busy, timeout, fail, done}, 32'b1000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
